// File: rtl/wb_regfile_if.sv
// Bus bundle for wb_regfile: one write-back port, two read ports and the write counter.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [15:0]       wr_cnt;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, wr_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Two-read / one-write register file with hard-wired zero register and commit counter.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [15:0]       cnt;
  logic              commit;

  // Writes to register 0 are dropped and do not count as commits.
  assign commit = bus.we && (bus.waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      cnt <= '0;
    end else if (commit) begin
      regs[bus.waddr] <= bus.wdata;
      cnt             <= cnt + 16'd1;
    end
  end

  // Gated so the count reads zero from the very first reset cycle.
  assign bus.wr_cnt = rst ? 16'd0 : cnt;

  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      bus.rdata1 = regs[bus.raddr1];
`ifdef REGFILE_WB_BYPASS_EN
      if (bus.we && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end
`endif
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      bus.rdata2 = regs[bus.raddr2];
`ifdef REGFILE_WB_BYPASS_EN
      if (bus.we && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end
`endif
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq [$];
  exp_t        mon_e;
  logic [31:0] mdl [DEPTH];
  int unsigned mcnt = 0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [31:0] model_read(bit r, bit re, logic [4:0] a,
                                             bit we, logic [4:0] wa, logic [31:0] wd);
    if (r || !re || a == 5'd0) return 32'd0;
    if (BYP && we && wa == a) return wd;
    return mdl[a];
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, queue the expected combinational response, advance the model.
  task automatic cycle(string name, bit r, bit we, logic [4:0] wa, logic [31:0] wd,
                       bit re1, logic [4:0] a1, bit re2, logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    bus.we     = we;
    bus.waddr  = wa;
    bus.wdata  = wd;
    bus.re1    = re1;
    bus.raddr1 = a1;
    bus.re2    = re2;
    bus.raddr2 = a2;
    e.name = name;
    e.r1   = model_read(r, re1, a1, we, wa, wd);
    e.r2   = model_read(r, re2, a2, we, wa, wd);
    e.cnt  = r ? 16'd0 : 16'(mcnt);
    sbq.push_back(e);
    if (r) begin
      foreach (mdl[i]) mdl[i] = 32'd0;
      mcnt = 0;
    end else if (we && wa != 5'd0) begin
      mdl[wa] = wd;
      mcnt    = (mcnt + 1) % 65536;
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk({mon_e.name, ".rdata1"}, bus.rdata1, mon_e.r1);
      chk({mon_e.name, ".rdata2"}, bus.rdata2, mon_e.r2);
      chk({mon_e.name, ".wr_cnt"}, {16'd0, bus.wr_cnt}, {16'd0, mon_e.cnt});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  wa, a1, a2;
    logic [31:0] wd;
    bit          r, we, re1, re2;
    foreach (mdl[i]) mdl[i] = 32'd0;
    rst = 1'b1; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;

    cycle("rst0",      1, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd5);
    cycle("rst1",      1, 1, 5'd5, 32'hFFFFFFFF, 1, 5'd5, 0, 5'd0);
    cycle("post_rst",  0, 0, 5'd0, 32'h0,        1, 5'd5, 0, 5'd0);
    cycle("wr3",       0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd3, 0, 5'd0);
    cycle("rd3",       0, 0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd3);
    cycle("wr0",       0, 1, 5'd0, 32'h12345678, 1, 5'd3, 1, 5'd0);
    cycle("rd0",       0, 0, 5'd0, 32'h0,        1, 5'd0, 1, 5'd0);
    cycle("wr7_old",   0, 1, 5'd7, 32'h11111111, 0, 5'd0, 0, 5'd0);
    cycle("wr7_same",  0, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 1, 5'd7);
    cycle("rd7",       0, 0, 5'd0, 32'h0,        1, 5'd7, 0, 5'd7);
    cycle("wr0_rd0",   0, 1, 5'd0, 32'hCAFEF00D, 1, 5'd0, 1, 5'd0);
    cycle("rst_mid",   1, 1, 5'd9, 32'h99999999, 1, 5'd9, 1, 5'd3);
    cycle("wr_after",  0, 1, 5'd9, 32'h0BADF00D, 1, 5'd9, 1, 5'd3);
    cycle("rd_after",  0, 0, 5'd0, 32'h0,        1, 5'd9, 1, 5'd3);

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      we  = $urandom_range(0, 1);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      re1 = ($urandom_range(0, 3) != 0);
      re2 = ($urandom_range(0, 3) != 0);
      a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle("rand", r, we, wa, wd, re1, a1, re2, a2);
    end

    cycle("wrap_rst", 1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 65536; i++) begin
      wa = 5'($urandom_range(1, 31));
      a1 = 5'($urandom_range(0, 31));
      cycle("wrap", 0, 1, wa, $urandom, 1, a1, 1, wa);
    end
    cycle("wrap_chk",  0, 0, 5'd0, 32'h0,        1, 5'd4, 1, 5'd1);
    cycle("wr4",       0, 1, 5'd4, 32'h44444444, 0, 5'd0, 0, 5'd0);
    cycle("rst_we4",   1, 1, 5'd4, 32'h55555555, 1, 5'd4, 1, 5'd4);
    cycle("rd4_after", 0, 0, 5'd0, 32'h0,        1, 5'd4, 1, 5'd4);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width (matches RegDataBus).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (matches RegAddrBus); depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset (RstEnable = 1).
REQ-005 SHALL have port we  input  1  write-back enable from the memory stage (WriteEnable = 1).
REQ-006 SHALL have port waddr  input  ADDR_W  write-back destination register.
REQ-007 SHALL have port wdata  input  DATA_W  write-back data.
REQ-008 SHALL have port re1  input  1  read port 1 enable.
REQ-009 SHALL have port raddr1  input  ADDR_W  read port 1 address.
REQ-010 SHALL have port rdata1  output  DATA_W  read port 1 data.
REQ-011 SHALL have port re2  input  1  read port 2 enable.
REQ-012 SHALL have port raddr2  input  ADDR_W  read port 2 address.
REQ-013 SHALL have port rdata2  output  DATA_W  read port 2 data.
REQ-014 SHALL have port wr_cnt  output  16  count of committed register writes since reset.

Function
REQ-015 SHALL hold 2**ADDR_W registers of DATA_W bits; register 0 reads as ZeroWord always.
REQ-016 SHALL commit wdata to reg[waddr] at the rising edge where rst=0, we=1 and waddr!=0.
REQ-017 SHALL discard writes with waddr=0 and leave every register unchanged.
REQ-018 SHALL not count discarded writes; wr_cnt SHALL increment by 1 on each committed write.
REQ-019 SHALL wrap wr_cnt from 0xFFFF to 0x0000 without saturating.
REQ-020 SHALL drive each read port combinationally (zero latency) in the same cycle as its address.
REQ-021 SHALL drive rdataN = ZeroWord when rst=1, reN=0 or raddrN=0, in that priority order.
REQ-022 SHALL drive rdataN = reg[raddrN] when reN=1 and raddrN!=0, unless REQ-031 applies.
REQ-023 SHALL serve both read ports independently; raddr1=raddr2 returns identical data on both.
REQ-024 SHALL keep the read path free of combinational loops; rdataN depends only on current inputs and stored state.

Reset
REQ-025 SHALL, on a rising edge with rst=1, clear every register and wr_cnt to zero.
REQ-026 SHALL ignore we while rst=1; a write presented in a reset cycle is lost.
REQ-027 SHALL treat reset asserted mid-stream as dominant; the first write after deassertion lands at the first edge with rst=0.
REQ-028 SHALL drive rdata1, rdata2 = ZeroWord and wr_cnt = 0 throughout reset.

Configuration
REQ-029 SHALL compile the write-to-read bypass only when macro REGFILE_WB_BYPASS_EN is defined.
REQ-030 SHALL, without REGFILE_WB_BYPASS_EN, return the stored value; a same-cycle write becomes visible the cycle after commit.
REQ-031 SHALL, with REGFILE_WB_BYPASS_EN, drive rdataN = wdata when reN=1, we=1, raddrN=waddr and waddr!=0, in the same cycle.
REQ-032 SHALL keep REQ-021 zero cases higher priority than bypass in both builds.

Verification
REQ-033 SHALL cover: rst=1 two cycles, then re1=1 raddr1=5 -> rdata1=0x00000000, wr_cnt=0.
REQ-034 SHALL cover: we=1 waddr=3 wdata=0xDEADBEEF, next cycle re1=1 raddr1=3 -> rdata1=0xDEADBEEF, wr_cnt=1.
REQ-035 SHALL cover: we=1 waddr=0 wdata=0x12345678, then raddr2=0 re2=1 -> rdata2=0, wr_cnt unchanged.
REQ-036 SHALL cover: same cycle we=1 waddr=7 wdata=0xA5A5A5A5, re1=1 raddr1=7 -> rdata1=0xA5A5A5A5 with REGFILE_WB_BYPASS_EN, old reg[7] without it.
REQ-037 SHALL cover: 65536 committed writes -> wr_cnt wraps to 0x0000; then rst=1 with we=1 waddr=4 -> reg[4]=0 after reset.
